nv_scan_chain_seq: RTL and testbench

Sequencer for a serial chain of scan-clearable state flops with an active-low async clear. It accepts one command at a time: CLEAR, SAVE or LOAD. CLEAR pulses the chain clear. SAVE shifts the chain out non-destructively by recirculating it. LOAD shifts new contents in and returns the old contents. It sits between a register/CSB-side requester and a retention/debug flop chain and owns the chain's clear, shift-enable and scan-in pins.

---
 rtl/nv_scan_chain_seq.sv | 109 ++++++++++
 tb/tb_nv_scan_chain_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nv_scan_chain_seq.sv
// Command sequencer for a serial scan-clearable flop chain: CLEAR pulses the
// chain clear, SAVE recirculates the chain out, LOAD shifts new data in and the old data out.
module nv_scan_chain_seq #(
  parameter int LEN        = 32,
  parameter int CLR_CYCLES = 4
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [LEN-1:0] cmd_data,
  output logic           done_valid,
  output logic [LEN-1:0] done_data,
  output logic           done_err,
  output logic           chain_clr_n,
  output logic           chain_se,
  output logic           chain_si,
  input  logic           chain_so,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2((LEN > CLR_CYCLES) ? LEN : CLR_CYCLES) + 1;
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(LEN - 1);
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_SAVE  = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE outside reset,
  // and anything presented while it is low is dropped, not queued.
  state_t          r_state;
  state_t          w_nxt;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [LEN-1:0]  r_sh;
  logic            r_ready;
  logic            r_clr_n;
  logic            r_se;
  logic            r_done_valid;
  logic            r_done_err;
  logic            w_accept;

  assign w_accept = r_ready & cmd_valid;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_CLEAR:         w_nxt = S_CLEAR;
            OP_SAVE, OP_LOAD: w_nxt = S_SHIFT;
            default:          w_nxt = S_DONE;
          endcase
        end
      end
      S_CLEAR: if (r_cnt == CLR_LAST)   w_nxt = S_DONE;
      S_SHIFT: if (r_cnt == SHIFT_LAST) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Pin-level outputs are registered from the next state so they switch
  // together with the state and drop on the same edge as a reset abort.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state      <= S_IDLE;
      r_op         <= 2'd0;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_ready      <= 1'b0;
      r_clr_n      <= 1'b1;
      r_se         <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_ready      <= (w_nxt == S_IDLE);
      r_clr_n      <= (w_nxt != S_CLEAR);
      r_se         <= (w_nxt == S_SHIFT);
      r_done_valid <= (w_nxt == S_DONE);
      r_done_err   <= w_accept && (cmd_op == 2'd0);
      if (w_accept) begin
        r_op  <= cmd_op;
        r_cnt <= '0;
        if (cmd_op == OP_LOAD) r_sh <= cmd_data;
      end else if (r_state == S_CLEAR || r_state == S_SHIFT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_SHIFT) r_sh <= {chain_so, r_sh[LEN-1:1]};
    end
  end

  // SAVE feeds the tail back to the head; LOAD feeds the payload LSB-first.
  assign chain_si    = (r_state == S_SHIFT) ? ((r_op == OP_SAVE) ? chain_so : r_sh[0]) : 1'b0;
  assign cmd_ready   = r_ready;
  assign chain_clr_n = r_clr_n;
  assign chain_se    = r_se;
  assign done_valid  = r_done_valid;
  assign done_err    = r_done_err;
  assign done_data   = r_sh;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_nv_scan_chain_seq.sv
// Directed bench for nv_scan_chain_seq with a behavioural 32-flop chain that
// has an async active-low clear and a tail serial output.
module tb_nv_scan_chain_seq;

  localparam int LEN = 32;
  localparam logic [31:0] SAVE_PAT  = 32'hA5C3_0F81;
  localparam logic [31:0] OLD_PAT   = 32'h1234_5678;
  localparam logic [31:0] LOAD_PAT  = 32'hDEAD_BEEF;
  localparam logic [31:0] ABORT_PAT = 32'h0F0F_3C3C;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        done_valid;
  logic [31:0] done_data;
  logic        done_err;
  logic        chain_clr_n;
  logic        chain_se;
  logic        chain_si;
  logic        chain_so;
  logic [1:0]  dbg_state;

  logic [31:0] chain;
  logic        preset_req;
  logic [31:0] preset_val;

  int n_checks;
  int n_errors;

  int done_cyc, se_cnt, se_first, se_last, clr_cnt, clr_first, clr_last, rdy_back, dv_cnt;
  logic        err_s;
  logic [31:0] dd_s;

  nv_scan_chain_seq #(.LEN(LEN), .CLR_CYCLES(4)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .done_valid     (done_valid),
    .done_data      (done_data),
    .done_err       (done_err),
    .chain_clr_n    (chain_clr_n),
    .chain_se       (chain_se),
    .chain_si       (chain_si),
    .chain_so       (chain_so),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural flop chain
  always @(posedge clk or negedge chain_clr_n) begin
    if (!chain_clr_n)   chain <= '0;
    else if (preset_req) chain <= preset_val;
    else if (chain_se)   chain <= {chain_si, chain[31:1]};
  end
  assign chain_so = chain[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic preset_chain(input logic [31:0] v);
    preset_val = v;
    preset_req = 1'b1;
    @(posedge clk);
    #1 preset_req = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with cmd_ready expected high; the command is taken at
  // the next edge T. Cycle k is sampled at the negedge following edge T+k-1.
  // With hold set, a CLEAR stays presented while busy and must be ignored.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] data, input bit hold);
    done_cyc = -1; se_cnt = 0; se_first = -1; se_last = -1;
    clr_cnt = 0; clr_first = -1; clr_last = -1; rdy_back = -1; dv_cnt = 0;
    err_s = 1'b0; dd_s = '0;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_op = 2'd1; cmd_data = ~data;
    end else begin
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    end
    for (int k = 1; k <= 60 && rdy_back < 0; k++) begin
      @(negedge clk);
      if (chain_se) begin
        se_cnt++; if (se_first < 0) se_first = k; se_last = k;
      end
      if (!chain_clr_n) begin
        clr_cnt++; if (clr_first < 0) clr_first = k; clr_last = k;
      end
      if (done_valid) begin
        dv_cnt++; done_cyc = k; err_s = done_err; dd_s = done_data;
      end
      if (cmd_ready) begin
        rdy_back = k;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
      end
    end
    check("ready_return_in_budget", 32'(rdy_back >= 0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; preset_req = 1'b0; preset_val = '0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 32'hFFFF_FFFF;

    // reset held for three edges with a command presented
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_clr_n", chain_clr_n, 1);
      check("rst_se", chain_se, 0);
      check("rst_si", chain_si, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_done_err", done_err, 0);
      check("rst_done_data", done_data, 0);
    end
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_done_valid", done_valid, 0);
    check("post_rst_se", chain_se, 0);

    // CLEAR
    preset_chain(32'hFFFF_FFFF);
    do_cmd(2'd1, 32'h0, 1'b0);
    check("clr_cycles", clr_cnt, 4);
    check("clr_first", clr_first, 1);
    check("clr_last", clr_last, 4);
    check("clr_se", se_cnt, 0);
    check("clr_done_cyc", done_cyc, 5);
    check("clr_done_pulses", dv_cnt, 1);
    check("clr_done_err", err_s, 0);
    check("clr_ready_back", rdy_back, 6);
    check("clr_chain", chain, 0);

    // SAVE, with a CLEAR held on the bus while busy
    preset_chain(SAVE_PAT);
    do_cmd(2'd2, 32'h0, 1'b1);
    check("save_data", dd_s, SAVE_PAT);
    check("save_chain", chain, SAVE_PAT);
    check("save_se_cycles", se_cnt, 32);
    check("save_se_first", se_first, 1);
    check("save_se_last", se_last, 32);
    check("save_done_cyc", done_cyc, 33);
    check("save_done_err", err_s, 0);
    check("save_no_clr", clr_cnt, 0);
    check("save_ready_back", rdy_back, 34);
    @(negedge clk);
    check("save_busy_cmd_dropped", chain_clr_n, 1);

    // LOAD then back-to-back SAVE
    preset_chain(OLD_PAT);
    do_cmd(2'd3, LOAD_PAT, 1'b0);
    check("load_old_data", dd_s, OLD_PAT);
    check("load_chain", chain, LOAD_PAT);
    check("load_done_cyc", done_cyc, 33);
    check("load_se_cycles", se_cnt, 32);
    do_cmd(2'd2, 32'h0, 1'b0);
    check("b2b_se_first", se_first, 1);
    check("b2b_save_data", dd_s, LOAD_PAT);
    check("b2b_chain", chain, LOAD_PAT);

    // illegal op
    do_cmd(2'd0, 32'h5555_AAAA, 1'b0);
    check("ill_done_cyc", done_cyc, 1);
    check("ill_done_err", err_s, 1);
    check("ill_done_data", dd_s, LOAD_PAT);
    check("ill_chain", chain, LOAD_PAT);
    check("ill_se", se_cnt, 0);
    check("ill_clr", clr_cnt, 0);
    check("ill_ready_back", rdy_back, 2);
    check("ill_err_cleared", done_err, 0);

    // reset abort during LOAD; chain is LOAD_PAT here
    check("abort_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = ABORT_PAT;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    repeat (10) @(negedge clk);
    check("abort_se_before", chain_se, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_se_off", chain_se, 0);
    check("abort_clr_n", chain_clr_n, 1);
    check("abort_done_valid", done_valid, 0);
    check("abort_done_data", done_data, 0);
    rst = 1'b0;
    dv = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_valid) dv++;
    end
    check("abort_no_done", dv, 0);
    do_cmd(2'd2, 32'h0, 1'b0);
    check("abort_save_data", dd_s, {ABORT_PAT[9:0], LOAD_PAT[31:10]});
    check("abort_save_done_cyc", done_cyc, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
